// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 128-point radix-2 SDF FFT
// sequencer (fft_seq_ctrl and its fill tracker).
package fft_pkg;

    localparam int N        = 7;                    // log2(FFT length)
    localparam int FFT_LEN  = 2**N;                 // samples per frame
    localparam int PIPE_LAT = FFT_LEN - 1 + N;      // advances from entry to result
    localparam int PEND_W   = 9;                    // holds PIPE_LAT + FFT_LEN
    localparam int ADV_W    = $clog2(PIPE_LAT + 1); // holds 0..PIPE_LAT

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fft_fill_tracker.sv
// Pipeline fill tracker: counts advances since the stream started (adv,
// saturating at PIPE_LAT), samples in flight (pend) and the output bin
// index (out_idx). Decides which pipeline output samples are real results.
module fft_fill_tracker
    import fft_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pipe_en,    // pipeline advances this cycle
    input  logic in_zero,    // the advancing sample is a flush zero
    input  logic clr,        // sequencer is entering IDLE
    output logic out_valid,  // pipeline output is a real result
    output logic out_sop,    // that result is bin 0 of a frame
    output logic last_emit,  // this emit empties the pipeline
    output logic pend_zero   // nothing in flight
);

    logic [ADV_W-1:0]  adv;
    logic [PEND_W-1:0] pend;
    logic [N-1:0]      out_idx;
    logic              accept;
    logic              adv_full;

    assign adv_full  = (adv == ADV_W'(PIPE_LAT));
    assign accept    = pipe_en & ~in_zero;
    assign out_valid = pipe_en & adv_full & (pend != '0);
    assign out_sop   = out_valid & (out_idx == '0);
    assign last_emit = out_valid & ~accept & (pend == PEND_W'(1));
    assign pend_zero = (pend == '0);

    // Track fill level, in-flight count and output bin index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adv     <= '0;
            pend    <= '0;
            out_idx <= '0;
        end else begin
            case ({accept, out_valid})
                2'b10:   pend <= pend + PEND_W'(1);
                2'b01:   pend <= pend - PEND_W'(1);
                default: pend <= pend;
            endcase
            if (clr) begin
                adv     <= '0;
                out_idx <= '0;
            end else begin
                if (pipe_en && !adv_full)
                    adv <= adv + ADV_W'(1);
                if (out_valid)
                    out_idx <= out_idx + N'(1);
            end
        end
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Master sequencer for the 128-point radix-2 SDF FFT pipeline. Generates the
// stage counter cnt_1 and the pipeline advance strobe, flushes the pipeline
// with zeros after the last frame and flags valid output samples.
// Optional feature macro FFT_CTRL_SOP_CHK_EN: adds the in_sop port and a
// sticky sop_err flag for a start-of-frame marker seen mid-frame; without it
// sop_err is tied low.
module fft_seq_ctrl
    import fft_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
`ifdef FFT_CTRL_SOP_CHK_EN
    input  logic         in_sop,
`endif
    output logic [N-1:0] cnt_1,
    output logic         pipe_en,
    output logic         in_zero,
    output logic         out_valid,
    output logic         out_sop,
    output logic         busy,
    output logic         sop_err
);

    state_t state;
    state_t state_nxt;
    logic   clr;
    logic   last_emit;
    logic   pend_zero;
    logic   at_boundary;

    assign at_boundary = (cnt_1 == '0);
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, advance strobe, flush select and IDLE-entry clear.
    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        pipe_en   = 1'b0;
        in_zero   = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                pipe_en = in_valid;
                if (in_valid)
                    state_nxt = RUN;
            end
            RUN: begin
                pipe_en = in_valid;
                // A gap mid-frame simply stalls; a gap on a frame boundary
                // starts the flush (or goes idle if nothing is in flight).
                if (!in_valid && at_boundary) begin
                    if (!pend_zero) begin
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = IDLE;
                        clr       = 1'b1;
                    end
                end
            end
            FLUSH: begin
                pipe_en = 1'b1;
                if (in_valid && at_boundary) begin
                    state_nxt = RUN;
                end else begin
                    in_zero = 1'b1;
                    if (last_emit) begin
                        state_nxt = IDLE;
                        clr       = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
        endcase
    end

    // Stage counter: one step per advance, wraps naturally at FFT_LEN,
    // restarts at 0 whenever the sequencer goes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_1 <= '0;
        else if (clr)
            cnt_1 <= '0;
        else if (pipe_en)
            cnt_1 <= cnt_1 + N'(1);
    end

`ifdef FFT_CTRL_SOP_CHK_EN
    // Sticky start-of-frame error; the counter is deliberately not resynchronised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sop_err <= 1'b0;
        else if (in_valid && in_sop && !at_boundary)
            sop_err <= 1'b1;
    end
`else
    assign sop_err = 1'b0;
`endif

    fft_fill_tracker u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_en   (pipe_en),
        .in_zero   (in_zero),
        .clr       (clr),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .last_emit (last_emit),
        .pend_zero (pend_zero)
    );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge. Advance-indexed counters are
// compared against hand-computed values (FFT_LEN=128, PIPE_LAT=134).
module tb_fft_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sop;
    logic [6:0] cnt_1;
    logic       pipe_en;
    logic       in_zero;
    logic       out_valid;
    logic       out_sop;
    logic       busy;
    logic       sop_err;

    int n_checks;
    int n_fail;

    // Per-test counters, all indexed by advance number (pipe_en cycles).
    int n_adv;
    int n_out;
    int n_sop;
    int n_zero;
    int n_zero_valid;
    int first_out;
    int last_out;
    int first_sop;

    // Values sampled on the most recent falling edge.
    logic       s_pipe_en;
    logic       s_in_zero;
    logic       s_out_valid;
    logic       s_busy;
    logic       s_sop_err;
    logic [6:0] s_cnt;

    fft_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef FFT_CTRL_SOP_CHK_EN
        .in_sop    (in_sop),
`endif
        .cnt_1     (cnt_1),
        .pipe_en   (pipe_en),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .busy      (busy),
        .sop_err   (sop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_counters();
        n_adv = 0; n_out = 0; n_sop = 0; n_zero = 0; n_zero_valid = 0;
        first_out = -1; last_out = -1; first_sop = -1;
    endtask

    // One clock: drive inputs, sample mid-cycle, update counters.
    task automatic cycle(input logic v, input logic s);
        in_valid = v;
        in_sop   = s;
        @(negedge clk);
        s_pipe_en   = pipe_en;
        s_in_zero   = in_zero;
        s_out_valid = out_valid;
        s_busy      = busy;
        s_sop_err   = sop_err;
        s_cnt       = cnt_1;
        if (in_valid && in_zero)
            n_zero_valid++;
        if (pipe_en) begin
            if (out_valid) begin
                if (n_out == 0)
                    first_out = n_adv;
                last_out = n_adv;
                n_out++;
                if (out_sop) begin
                    if (n_sop == 0)
                        first_sop = n_adv;
                    n_sop++;
                end
            end
            if (in_zero)
                n_zero++;
            n_adv++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_valid(input int cycles);
        for (int i = 0; i < cycles; i++)
            cycle(1'b1, 1'b0);
    endtask

    task automatic drive_idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            cycle(1'b0, 1'b0);
    endtask

    // Hold in_valid low until busy drops, bounded.
    task automatic drain(input string tag);
        int k;
        k = 0;
        do begin
            cycle(1'b0, 1'b0);
            k++;
        end while (s_busy && k < 600);
        check({tag, "_drain_done"}, int'(s_busy), 0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One 128-sample frame from IDLE, then flush to IDLE.
    task automatic single_frame(input string tag);
        clear_counters();
        drive_valid(128);
        drain(tag);
        check({tag, "_first_out_adv"}, first_out, 134);
        check({tag, "_first_sop_adv"}, first_sop, 134);
        check({tag, "_n_out"},         n_out,     128);
        check({tag, "_contiguous"},    last_out - first_out + 1, 128);
        check({tag, "_n_sop"},         n_sop,     1);
        check({tag, "_n_adv"},         n_adv,     262);
        check({tag, "_n_zero"},        n_zero,    134);
        cycle(1'b0, 1'b0);
        check({tag, "_idle_cnt"},     int'(s_cnt),       0);
        check({tag, "_idle_pipe_en"}, int'(s_pipe_en),   0);
        check({tag, "_idle_out"},     int'(s_out_valid), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b0;
        clear_counters();

        // Reset state.
        #12;
        check("rst_cnt",       int'(cnt_1),     0);
        check("rst_pipe_en",   int'(pipe_en),   0);
        check("rst_in_zero",   int'(in_zero),   0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sop",   int'(out_sop),   0);
        check("rst_busy",      int'(busy),      0);
        check("rst_sop_err",   int'(sop_err),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);

        // 1: single frame.
        single_frame("t1");

        // 2: three back-to-back frames; no flush between them.
        clear_counters();
        drive_valid(384);
        check("t2_zero_during_input", n_zero_valid, 0);
        check("t2_zero_before_end",   n_zero,       0);
        drain("t2");
        check("t2_first_out_adv", first_out, 134);
        check("t2_n_out",         n_out,     384);
        check("t2_contiguous",    last_out - first_out + 1, 384);
        check("t2_n_sop",         n_sop,     3);
        check("t2_n_adv",         n_adv,     518);
        check("t2_n_zero",        n_zero,    134);

        // 3: in_valid low for 5 cycles at cnt_1=40 stalls everything.
        clear_counters();
        drive_valid(40);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            check("t3_stall_cnt",     int'(s_cnt),       40);
            check("t3_stall_pipe_en", int'(s_pipe_en),   0);
            check("t3_stall_out",     int'(s_out_valid), 0);
        end
        check("t3_adv_frozen", n_adv, 40);
        drive_valid(88);
        drain("t3");
        check("t3_first_out_adv", first_out, 134);
        check("t3_n_out",         n_out,     128);
        check("t3_contiguous",    last_out - first_out + 1, 128);
        check("t3_n_adv",         n_adv,     262);

        // 4: new frame during FLUSH. A request at flush cycle 20 (cnt_1=20) is
        // not a frame boundary and stays flushed; the next boundary accepts it.
        clear_counters();
        drive_valid(128);
        drive_idle(1);
        drive_idle(20);
        cycle(1'b1, 1'b0);
        check("t4_mid_cnt",     int'(s_cnt),     20);
        check("t4_mid_in_zero", int'(s_in_zero), 1);
        check("t4_mid_pipe_en", int'(s_pipe_en), 1);
        drive_idle(107);
        cycle(1'b1, 1'b0);
        check("t4_acc_cnt",     int'(s_cnt),     0);
        check("t4_acc_in_zero", int'(s_in_zero), 0);
        check("t4_acc_pipe_en", int'(s_pipe_en), 1);
        cycle(1'b1, 1'b0);
        check("t4_run_in_zero", int'(s_in_zero), 0);
        check("t4_run_busy",    int'(s_busy),    1);
        check("t4_run_cnt",     int'(s_cnt),     1);
        drive_valid(126);
        drain("t4");
        check("t4_first_out_adv", first_out,    134);
        check("t4_n_out",         n_out,        256);
        check("t4_contiguous",    last_out - first_out + 1, 256);
        check("t4_n_sop",         n_sop,        2);
        check("t4_n_adv",         n_adv,        390);
        check("t4_n_zero",        n_zero,       134);
        check("t4_zero_valid",    n_zero_valid, 1);

        // 5: asynchronous reset at cnt_1=64, then a clean frame.
        drive_valid(64);
        check("t5_pre_cnt", int'(cnt_1), 64);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5_rst_cnt",       int'(cnt_1),     0);
        check("t5_rst_busy",      int'(busy),      0);
        check("t5_rst_pipe_en",   int'(pipe_en),   0);
        check("t5_rst_in_zero",   int'(in_zero),   0);
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_out_sop",   int'(out_sop),   0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        single_frame("t5");

`ifdef FFT_CTRL_SOP_CHK_EN
        // 6: in_sop at cnt_1=10 sets sticky sop_err; counter carries on.
        pulse_reset();
        cycle(1'b1, 1'b1);
        check("t6_sop_at_zero", int'(s_sop_err), 0);
        drive_valid(9);
        cycle(1'b1, 1'b1);
        check("t6_sop_cnt",    int'(s_cnt),     10);
        check("t6_sop_before", int'(s_sop_err), 0);
        cycle(1'b1, 1'b0);
        check("t6_err_set",  int'(s_sop_err), 1);
        check("t6_cnt_next", int'(s_cnt),     11);
        drive_valid(116);
        drain("t6");
        check("t6_err_sticky", int'(sop_err), 1);
`else
        check("sop_err_tied", int'(sop_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
